// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multi-cycle IF/ID/EXE/MEM/WB sequencer. Owns pc, npc and ir.
// It handshakes with instruction and data memory over req/ack with any latency,
// traps to ERR on a bus timeout (optional) and counts retired instructions.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   inst_req/inst_addr/inst_rdata/inst_ack   instruction fetch handshake
//   ir                             instruction register
//   dec_nowb/dec_load/dec_store/dec_gr_we    decoder class bits, valid in ID
//   br_taken/br_target             redirect, valid in ID
//   alu_result/rkd_value           ALU result and store data, valid in EXE
//   data_req/data_we/data_addr/data_wdata/data_rdata/data_ack  data handshake
//   rf_we/wb_data                  regfile write port, WB only
//   wb_pc, state, bus_err, instret debug/status
module mc_seq_ctrl #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h1c000000),
  parameter int unsigned     TIMEOUT  = 0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             inst_req,
  output logic [PC_W-1:0]  inst_addr,
  input  logic [31:0]      inst_rdata,
  input  logic             inst_ack,
  output logic [31:0]      ir,
  input  logic             dec_nowb,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_gr_we,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      rkd_value,
  output logic             data_req,
  output logic             data_we,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  input  logic [31:0]      data_rdata,
  input  logic             data_ack,
  output logic             rf_we,
  output logic [31:0]      wb_data,
  output logic [PC_W-1:0]  wb_pc,
  output logic [2:0]       state,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned       WAIT_W    = 32;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, npc_q, npc_d;
  logic [31:0]       ir_q, ir_d;
  logic              load_q, load_d, store_q, store_d, gr_we_q, gr_we_d;
  logic [31:0]       res_q, res_d, wd_q, wd_d, wb_data_q, wb_data_d;
  logic              inst_req_q, inst_req_d, data_req_q, data_req_d;
  logic              data_we_q, data_we_d, rf_we_q, rf_we_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              retire;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  // Next-state, datapath latches and registered-output precompute.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    ir_d      = ir_q;
    load_d    = load_q;
    store_d   = store_q;
    gr_we_d   = gr_we_q;
    res_d     = res_q;
    wd_d      = wd_q;
    wb_data_d = wb_data_q;
    bus_err_d = bus_err_q;
    wait_d    = '0;
    retire    = 1'b0;

    unique case (state_q)
      S_IF: begin
        // The first cycle after reset has no request out, so nothing to wait on.
        if (inst_req_q) begin
          if (inst_ack) begin
            ir_d    = inst_rdata;
            state_d = S_ID;
          end else if (timeout_hit) begin
            state_d   = S_ERR;
            bus_err_d = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      S_ID: begin
        load_d  = dec_load;
        store_d = dec_store;
        gr_we_d = dec_gr_we;
        npc_d   = br_taken ? br_target : pc_q + PC_W'(4);
        if (dec_nowb) begin
          pc_d    = npc_d;
          retire  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        res_d = alu_result;
        wd_d  = rkd_value;
        if (load_q || store_q) begin
          state_d = S_MEM;
        end else begin
          wb_data_d = alu_result;
          state_d   = S_WB;
        end
      end
      S_MEM: begin
        if (data_ack) begin
          if (store_q) begin
            pc_d    = npc_q;
            retire  = 1'b1;
            state_d = S_IF;
          end else begin
            wb_data_d = data_rdata;
            state_d   = S_WB;
          end
        end else if (timeout_hit) begin
          state_d   = S_ERR;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        pc_d    = npc_q;
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase

    instret_d  = retire ? instret_q + CNT_W'(1) : instret_q;
    // Strobes are registered from the next state so they line up with it.
    inst_req_d = (state_d == S_IF);
    data_req_d = (state_d == S_MEM);
    data_we_d  = (state_d == S_MEM) && store_d;
    rf_we_d    = (state_d == S_WB) && gr_we_d;
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IF;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC;
      ir_q       <= '0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      gr_we_q    <= 1'b0;
      res_q      <= '0;
      wd_q       <= '0;
      wb_data_q  <= '0;
      inst_req_q <= 1'b0;
      data_req_q <= 1'b0;
      data_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      instret_q  <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      ir_q       <= ir_d;
      load_q     <= load_d;
      store_q    <= store_d;
      gr_we_q    <= gr_we_d;
      res_q      <= res_d;
      wd_q       <= wd_d;
      wb_data_q  <= wb_data_d;
      inst_req_q <= inst_req_d;
      data_req_q <= data_req_d;
      data_we_q  <= data_we_d;
      rf_we_q    <= rf_we_d;
      bus_err_q  <= bus_err_d;
      instret_q  <= instret_d;
      wait_q     <= wait_d;
    end
  end

  assign inst_req   = inst_req_q;
  assign inst_addr  = pc_q;
  assign ir         = ir_q;
  assign data_req   = data_req_q;
  assign data_we    = data_we_q;
  assign data_addr  = res_q;
  assign data_wdata = wd_q;
  assign rf_we      = rf_we_q;
  assign wb_data    = wb_data_q;
  assign wb_pc      = pc_q;
  assign state      = state_q;
  assign bus_err    = bus_err_q;
  assign instret    = instret_q;

endmodule
